// File: rtl/onehot_encoder_pipe.sv
// Streaming one-hot to binary encoder: per-segment partial encode, then combine.
// Non-one-hot inputs are flagged on m_err and counted in a saturating counter.
`timescale 1ns/1ps
module onehot_encoder_pipe #(
    parameter int WIDTH     = 32,
    parameter int SEGMENTS  = 4,
    parameter int LATENCY   = 2,
    parameter int CNT_WIDTH = 16,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [WIDTH-1:0]     s_dat,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [WIDTH_LOG-1:0] m_idx,
    output logic                 m_any,
    output logic                 m_err,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam int SEG_W   = WIDTH / SEGMENTS;
    localparam int SEG_LOG = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("onehot_encoder_pipe: WIDTH must be a power of two >= 2");
    end
    if (SEGMENTS < 1 || (SEGMENTS & (SEGMENTS - 1)) != 0 || SEGMENTS > WIDTH / 2) begin : g_bad_seg
        $error("onehot_encoder_pipe: SEGMENTS must be a power of two in [1, WIDTH/2]");
    end
    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_lat
        $error("onehot_encoder_pipe: LATENCY must be 1 or 2");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("onehot_encoder_pipe: CNT_WIDTH must be >= 1");
    end

    logic [SEGMENTS-1:0][SEG_LOG-1:0] seg_idx_c;
    logic [SEGMENTS-1:0]              seg_any_c;
    logic [SEGMENTS-1:0]              seg_err_c;

    // Indices are OR-ed rather than priority-selected, so a single set bit yields its exact index.
    for (genvar gi = 0; gi < SEGMENTS; gi++) begin : g_seg
        logic [SEG_LOG-1:0] idx;
        logic               seen;
        logic               err;
        always_comb begin
            idx  = '0;
            seen = 1'b0;
            err  = 1'b0;
            for (int j = 0; j < SEG_W; j++) begin
                if (s_dat[gi*SEG_W + j]) begin
                    idx  = idx | SEG_LOG'(j);
                    err  = err | seen;
                    seen = 1'b1;
                end
            end
        end
        assign seg_idx_c[gi] = idx;
        assign seg_any_c[gi] = seen;
        assign seg_err_c[gi] = err;
    end

    logic [SEGMENTS-1:0][SEG_LOG-1:0] cmb_idx;
    logic [SEGMENTS-1:0]              cmb_any;
    logic [SEGMENTS-1:0]              cmb_err;
    logic                             up_vld;
    logic                             out_rdy;
    logic                             out_full_reg;

    assign out_rdy = ~out_full_reg | m_rdy;

    if (LATENCY == 2) begin : g_lat2
        logic [SEGMENTS-1:0][SEG_LOG-1:0] seg_idx_reg;
        logic [SEGMENTS-1:0]              seg_any_reg;
        logic [SEGMENTS-1:0]              seg_err_reg;
        logic                             s1_full_reg;
        logic                             s1_rdy;

        assign s1_rdy = ~s1_full_reg | out_rdy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_full_reg <= 1'b0;
            end else begin
                s1_full_reg <= (s_vld & s1_rdy) | (s1_full_reg & ~out_rdy);
            end
        end

        always_ff @(posedge clk) begin
            if (s_vld & s1_rdy) begin
                seg_idx_reg <= seg_idx_c;
                seg_any_reg <= seg_any_c;
                seg_err_reg <= seg_err_c;
            end
        end

        assign cmb_idx = seg_idx_reg;
        assign cmb_any = seg_any_reg;
        assign cmb_err = seg_err_reg;
        assign up_vld  = s1_full_reg;
        assign s_rdy   = s1_rdy;
    end else begin : g_lat1
        assign cmb_idx = seg_idx_c;
        assign cmb_any = seg_any_c;
        assign cmb_err = seg_err_c;
        assign up_vld  = s_vld;
        assign s_rdy   = out_rdy;
    end

    logic [WIDTH_LOG-1:0] idx_next;
    logic                 any_next;
    logic                 err_next;
    logic                 seg_seen;

    // Segment number forms the upper index bits; two active segments also means multi-hot.
    always_comb begin
        idx_next = '0;
        any_next = 1'b0;
        err_next = 1'b0;
        seg_seen = 1'b0;
        for (int k = 0; k < SEGMENTS; k++) begin
            if (cmb_any[k]) begin
                idx_next = idx_next | WIDTH_LOG'(k * SEG_W);
                err_next = err_next | seg_seen;
                seg_seen = 1'b1;
            end
            idx_next = idx_next | WIDTH_LOG'(cmb_idx[k]);
            err_next = err_next | cmb_err[k];
            any_next = any_next | cmb_any[k];
        end
    end

    logic [WIDTH_LOG-1:0] m_idx_reg;
    logic                 m_any_reg;
    logic                 m_err_reg;
    logic [CNT_WIDTH-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_full_reg <= 1'b0;
            m_idx_reg    <= '0;
            m_any_reg    <= 1'b0;
            m_err_reg    <= 1'b0;
        end else if (up_vld & out_rdy) begin
            out_full_reg <= 1'b1;
            m_idx_reg    <= idx_next;
            m_any_reg    <= any_next;
            m_err_reg    <= err_next;
        end else if (m_rdy) begin
            out_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (cnt_clr) begin
            err_cnt_reg <= '0;
        end else if (out_full_reg & m_rdy & m_err_reg & ~(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign m_vld   = out_full_reg;
    assign m_idx   = m_idx_reg;
    assign m_any   = m_any_reg;
    assign m_err   = m_err_reg;
    assign err_cnt = err_cnt_reg;

endmodule
